// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: a five-state FSM (IF, ID, EXE, MEM, WB) with decoded controls.
// Defining MC_CU_HAMM_EN adds the hamm R-type instruction (func 000001).
`timescale 1ns/1ps
module mc_cu (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_rdy,
    output logic [2:0] state,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    state_t cur_state, next_state;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_hamm;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic is_shift, r_alu, i_alu, supported;
    logic [3:0] op_aluc;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type & (func == 6'b100000);
    assign i_sub  = r_type & (func == 6'b100010);
    assign i_and  = r_type & (func == 6'b100100);
    assign i_or   = r_type & (func == 6'b100101);
    assign i_xor  = r_type & (func == 6'b100110);
    assign i_sll  = r_type & (func == 6'b000000);
    assign i_srl  = r_type & (func == 6'b000010);
    assign i_sra  = r_type & (func == 6'b000011);
    assign i_jr   = r_type & (func == 6'b001000);
`ifdef MC_CU_HAMM_EN
    assign i_hamm = r_type & (func == 6'b000001);
`else
    assign i_hamm = 1'b0;
`endif
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign is_shift  = i_sll | i_srl | i_sra;
    assign r_alu     = i_add | i_sub | i_and | i_or | i_xor | is_shift | i_hamm;
    assign i_alu     = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign supported = r_alu | i_jr | i_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

    // ALU operation selected by the instruction itself; EXE overrides it for memory and branch ops.
    always_comb begin
        op_aluc = 4'b0000;
        if (i_sub)                op_aluc = 4'b0100;
        else if (i_and | i_andi)  op_aluc = 4'b0001;
        else if (i_or | i_ori)    op_aluc = 4'b0101;
        else if (i_xor | i_xori)  op_aluc = 4'b0010;
        else if (i_lui)           op_aluc = 4'b0110;
        else if (i_sll)           op_aluc = 4'b0011;
        else if (i_srl)           op_aluc = 4'b0111;
        else if (i_sra)           op_aluc = 4'b1111;
        else if (i_hamm)          op_aluc = 4'b1011;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            cur_state <= S_IF;
        else
            cur_state <= next_state;
    end

    assign state = cur_state;

    // Next-state and control decode; write enables are forced low while reset is held.
    always_comb begin
        next_state = S_IF;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        illegal  = 1'b0;
        case (cur_state)
            S_IF: begin
                alusrcb    = 2'b01;
                wir        = mem_rdy;
                wpc        = mem_rdy;
                next_state = mem_rdy ? S_ID : S_IF;
            end
            S_ID: begin
                if (i_j) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                end else if (i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                end else if (i_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end else if (!supported) begin
                    illegal  = 1'b1;
                end else begin
                    alusrcb    = 2'b11;
                    sext       = 1'b1;
                    next_state = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                aluc    = op_aluc;
                if (r_alu) begin
                    shift      = is_shift;
                    next_state = S_WB;
                end else if (i_alu) begin
                    alusrcb    = 2'b10;
                    sext       = i_addi;
                    next_state = S_WB;
                end else if (i_lw | i_sw) begin
                    alusrcb    = 2'b10;
                    sext       = 1'b1;
                    aluc       = 4'b0000;
                    next_state = S_MEM;
                end else if (i_beq | i_bne) begin
                    aluc = 4'b0100;
                    if ((i_beq & z) | (i_bne & ~z)) begin
                        wpc      = 1'b1;
                        pcsource = 2'b01;
                    end
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (i_lw)
                    next_state = mem_rdy ? S_WB : S_MEM;
                else if (i_sw) begin
                    wmem       = 1'b1;
                    next_state = mem_rdy ? S_IF : S_MEM;
                end
            end
            S_WB: begin
                wreg  = 1'b1;
                m2reg = i_lw;
                regrt = i_alu | i_lw;
            end
            default: next_state = S_IF;
        endcase
        if (!resetn) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Randomized scoreboard bench for mc_cu: an instruction-level model queues the expected
// per-cycle controls and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mc_cu;

    localparam int CL_R = 0, CL_SHIFT = 1, CL_I = 2, CL_ADDI = 3, CL_LW = 4, CL_SW = 5;
    localparam int CL_BEQ = 6, CL_BNE = 7, CL_J = 8, CL_JAL = 9, CL_JR = 10, CL_ILL = 11;
    localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        int         cls;
        logic [3:0] aluc;
    } instr_t;

    typedef struct packed {
        logic [2:0] state;
        logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsource;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        string label;
    } sb_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] op, func;
    logic       z, mem_rdy;
    logic [2:0] state;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;

    instr_t tbl[$];
    sb_t    sb[$];
    instr_t rst_ins;
    int     vectors = 0;
    int     miscompares = 0;

    mc_cu dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .state(state), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .regrt(regrt), .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void add_instr(string n, logic [5:0] o, logic [5:0] f, int c, logic [3:0] a);
        instr_t t;
        t.name = n; t.op = o; t.func = f; t.cls = c; t.aluc = a;
        tbl.push_back(t);
    endfunction

    function automatic instr_t lookup(string n);
        instr_t t;
        t = tbl[0];
        foreach (tbl[i]) if (tbl[i].name == n) t = tbl[i];
        return t;
    endfunction

    function automatic string pname(int p);
        case (p)
            P_IF:    return "IF";
            P_ID:    return "ID";
            P_EXE:   return "EXE";
            P_MEM:   return "MEM";
            default: return "WB";
        endcase
    endfunction

    // Expected controls for one cycle of an instruction, from the per-state instruction rules.
    function automatic ctl_t model(int phase, instr_t ins, logic zv, logic rdy, logic rst_n);
        ctl_t e;
        logic taken;
        e = '0;
        e.state = 3'(phase);
        case (phase)
            P_IF: begin
                e.alusrcb = 2'b01;
                e.wir = rdy;
                e.wpc = rdy;
            end
            P_ID: begin
                case (ins.cls)
                    CL_J:   begin e.wpc = 1'b1; e.pcsource = 2'b11; end
                    CL_JAL: begin e.wpc = 1'b1; e.pcsource = 2'b11; e.wreg = 1'b1; e.jal = 1'b1; end
                    CL_JR:  begin e.wpc = 1'b1; e.pcsource = 2'b10; end
                    CL_ILL: e.illegal = 1'b1;
                    default: begin e.alusrcb = 2'b11; e.sext = 1'b1; end
                endcase
            end
            P_EXE: begin
                e.alusrca = 1'b1;
                case (ins.cls)
                    CL_R:     e.aluc = ins.aluc;
                    CL_SHIFT: begin e.aluc = ins.aluc; e.shift = 1'b1; end
                    CL_I, CL_ADDI: begin
                        e.alusrcb = 2'b10;
                        e.aluc = ins.aluc;
                        e.sext = (ins.cls == CL_ADDI);
                    end
                    CL_LW, CL_SW: begin e.alusrcb = 2'b10; e.sext = 1'b1; end
                    CL_BEQ, CL_BNE: begin
                        e.aluc = 4'b0100;
                        taken = (ins.cls == CL_BEQ) ? zv : !zv;
                        e.wpc = taken;
                        e.pcsource = taken ? 2'b01 : 2'b00;
                    end
                    default: ;
                endcase
            end
            P_MEM: begin
                e.iord = 1'b1;
                e.wmem = (ins.cls == CL_SW);
            end
            default: begin
                e.wreg = 1'b1;
                e.m2reg = (ins.cls == CL_LW);
                e.regrt = (ins.cls == CL_I) || (ins.cls == CL_ADDI) || (ins.cls == CL_LW);
            end
        endcase
        if (!rst_n) begin
            e.wpc = 1'b0; e.wir = 1'b0; e.wmem = 1'b0; e.wreg = 1'b0; e.illegal = 1'b0;
        end
        return e;
    endfunction

    task automatic check_output(ctl_t exp, string label);
        ctl_t act;
        act = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca,
               alusrcb, aluc, pcsource, illegal};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", label, act, exp);
        end
    endtask

    always @(negedge clock) begin
        sb_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check_output(it.exp, it.label);
        end
    end

    task automatic apply_stimulus(int phase, instr_t ins, logic rdy, logic zv);
        sb_t item;
        @(posedge clock);
        #1;
        if (phase == P_IF) begin
            op   = 6'($urandom);
            func = 6'($urandom);
        end else begin
            op   = ins.op;
            func = ins.func;
        end
        mem_rdy = rdy;
        z = zv;
        item.exp = model(phase, ins, zv, rdy, resetn);
        item.label = {ins.name, "/", pname(phase)};
        sb.push_back(item);
    endtask

    task automatic run_instr(instr_t ins, int if_stalls, int mem_stalls, logic zv);
        for (int i = 0; i < if_stalls; i++) apply_stimulus(P_IF, ins, 1'b0, 1'($urandom));
        apply_stimulus(P_IF, ins, 1'b1, 1'($urandom));
        apply_stimulus(P_ID, ins, 1'($urandom), 1'($urandom));
        case (ins.cls)
            CL_J, CL_JAL, CL_JR, CL_ILL: ;
            CL_BEQ, CL_BNE: apply_stimulus(P_EXE, ins, 1'($urandom), zv);
            CL_LW, CL_SW: begin
                apply_stimulus(P_EXE, ins, 1'($urandom), 1'($urandom));
                for (int i = 0; i < mem_stalls; i++) apply_stimulus(P_MEM, ins, 1'b0, 1'($urandom));
                apply_stimulus(P_MEM, ins, 1'b1, 1'($urandom));
                if (ins.cls == CL_LW) apply_stimulus(P_WB, ins, 1'($urandom), 1'($urandom));
            end
            default: begin
                apply_stimulus(P_EXE, ins, 1'($urandom), 1'($urandom));
                apply_stimulus(P_WB, ins, 1'($urandom), 1'($urandom));
            end
        endcase
    endtask

    // A stalled store is aborted by an asynchronous reset pulse, then fetching restarts.
    task automatic sw_reset_abort();
        instr_t s;
        s = lookup("sw");
        apply_stimulus(P_IF, s, 1'b1, 1'b0);
        apply_stimulus(P_ID, s, 1'b0, 1'b0);
        apply_stimulus(P_EXE, s, 1'b1, 1'b0);
        apply_stimulus(P_MEM, s, 1'b0, 1'b0);
        apply_stimulus(P_MEM, s, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        mem_rdy = 1'b1;
        resetn = 1'b0;
        #1;
        check_output(model(P_IF, rst_ins, z, 1'b1, 1'b0), "sw/async_reset");
        apply_stimulus(P_IF, rst_ins, 1'b1, 1'b1);
        apply_stimulus(P_IF, rst_ins, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        resetn = 1'b1;
        run_instr(lookup("add"), 0, 0, 1'b0);
    endtask

    initial begin
        int idx;
        resetn = 1'b0; mem_rdy = 1'b1; op = 6'd0; func = 6'd0; z = 1'b0;
        rst_ins.name = "reset"; rst_ins.op = 6'd0; rst_ins.func = 6'd0;
        rst_ins.cls = CL_ILL; rst_ins.aluc = 4'b0000;

        add_instr("add",  6'b000000, 6'b100000, CL_R,     4'b0000);
        add_instr("sub",  6'b000000, 6'b100010, CL_R,     4'b0100);
        add_instr("and",  6'b000000, 6'b100100, CL_R,     4'b0001);
        add_instr("or",   6'b000000, 6'b100101, CL_R,     4'b0101);
        add_instr("xor",  6'b000000, 6'b100110, CL_R,     4'b0010);
        add_instr("sll",  6'b000000, 6'b000000, CL_SHIFT, 4'b0011);
        add_instr("srl",  6'b000000, 6'b000010, CL_SHIFT, 4'b0111);
        add_instr("sra",  6'b000000, 6'b000011, CL_SHIFT, 4'b1111);
        add_instr("jr",   6'b000000, 6'b001000, CL_JR,    4'b0000);
        add_instr("addi", 6'b001000, 6'b010101, CL_ADDI,  4'b0000);
        add_instr("andi", 6'b001100, 6'b111000, CL_I,     4'b0001);
        add_instr("ori",  6'b001101, 6'b000111, CL_I,     4'b0101);
        add_instr("xori", 6'b001110, 6'b101010, CL_I,     4'b0010);
        add_instr("lui",  6'b001111, 6'b110011, CL_I,     4'b0110);
        add_instr("lw",   6'b100011, 6'b001100, CL_LW,    4'b0000);
        add_instr("sw",   6'b101011, 6'b100001, CL_SW,    4'b0000);
        add_instr("beq",  6'b000100, 6'b011011, CL_BEQ,   4'b0100);
        add_instr("bne",  6'b000101, 6'b000110, CL_BNE,   4'b0100);
        add_instr("j",    6'b000010, 6'b111111, CL_J,     4'b0000);
        add_instr("jal",  6'b000011, 6'b010010, CL_JAL,   4'b0000);
`ifdef MC_CU_HAMM_EN
        add_instr("hamm", 6'b000000, 6'b000001, CL_R,     4'b1011);
`else
        add_instr("hamm", 6'b000000, 6'b000001, CL_ILL,   4'b0000);
`endif
        add_instr("ill_op",   6'b111111, 6'b100000, CL_ILL, 4'b0000);
        add_instr("ill_cop",  6'b010000, 6'b000000, CL_ILL, 4'b0000);
        add_instr("ill_func", 6'b000000, 6'b000101, CL_ILL, 4'b0000);

        apply_stimulus(P_IF, rst_ins, 1'b1, 1'b1);
        apply_stimulus(P_IF, rst_ins, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        resetn = 1'b1;

        run_instr(lookup("add"), 0, 0, 1'b0);
        run_instr(lookup("lw"), 2, 2, 1'b0);
        run_instr(lookup("beq"), 0, 0, 1'b1);
        run_instr(lookup("beq"), 0, 0, 1'b0);
        run_instr(lookup("bne"), 1, 0, 1'b0);
        run_instr(lookup("jal"), 0, 0, 1'b0);
        run_instr(lookup("ill_op"), 0, 0, 1'b0);
        run_instr(lookup("hamm"), 0, 0, 1'b0);
        run_instr(lookup("sw"), 1, 3, 1'b0);
        sw_reset_abort();

        repeat (300) begin
            idx = $urandom_range(0, tbl.size() - 1);
            run_instr(tbl[idx], $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 clock  input  1  rising-edge clock; the only clock in the block.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 op  input  6  opcode field of the instruction register.
REQ-004 func  input  6  function field of the instruction register.
REQ-005 z  input  1  ALU zero flag, valid in the EXE state.
REQ-006 mem_rdy  input  1  memory acknowledge; the current access completes in a cycle where it is 1.
REQ-007 state  output  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100.
REQ-008 wpc, wir, wmem, wreg  output  1 each  PC, instruction-register, memory and register-file write enables.
REQ-009 iord  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 regrt, m2reg, jal, sext, shift  output  1 each  same meaning as the single-cycle control signals.
REQ-011 alusrca  output  1  ALU A select: 0=PC, 1=register A.
REQ-012 alusrcb  output  2  ALU B select: 00=register B, 01=constant 4, 10=extended immediate, 11=extended immediate shifted left 2.
REQ-013 aluc  output  4  ALU operation, in the existing ALU encoding.
REQ-014 pcsource  output  2  next-PC select: 00=ALU output, 01=branch target register, 10=register rs, 11=jump address.
REQ-015 illegal  output  1  one-cycle pulse in ID when the instruction is not supported.

Function
REQ-016 The block SHALL be a five-state FSM with one registered state; all other outputs SHALL be decoded combinationally from state, op, func, z and mem_rdy.
REQ-017 Any output not listed for the current state SHALL be 0.
REQ-018 Supported instructions: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal, plus hamm when configured.
REQ-019 Opcode/func decode SHALL match the single-cycle unit bit for bit.
REQ-020 aluc encodings SHALL be:
- add = 0000; sub = 0100; and = 0001; or = 0101; xor = 0010; lui = 0110
- sll = 0011; srl = 0111; sra = 1111; hamm = 1011
REQ-021 IF state:
- iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00
- if mem_rdy=1: wir=1, wpc=1, next state ID
- otherwise: stay in IF with wir=0 and wpc=0 (unbounded wait)
REQ-022 ID state:
- j: wpc=1, pcsource=11, next IF
- jal: wpc=1, pcsource=11, wreg=1, jal=1 (writes the incremented PC to $31), next IF
- jr: wpc=1, pcsource=10, next IF
- illegal: illegal=1, no write enables, next IF
- all other instructions: alusrca=0, alusrcb=11, aluc=add, sext=1 (branch target captured), next EXE
REQ-023 EXE state, R-type: alusrca=1, alusrcb=00, shift=1 for sll/srl/sra, next WB.
REQ-024 EXE state, I-type ALU: alusrca=1, alusrcb=10, sext=1 only for addi, next WB.
REQ-025 EXE state, lw/sw: alusrca=1, alusrcb=10, sext=1, aluc=add, next MEM.
REQ-026 EXE state, beq/bne:
- alusrca=1, alusrcb=00, aluc=sub, next IF
- wpc=1 with pcsource=01 only when (beq & z) | (bne & ~z)
REQ-027 MEM state:
- iord=1 for both lw and sw
- lw: next WB when mem_rdy=1, else stay in MEM
- sw: wmem=1 for every MEM cycle; next IF when mem_rdy=1, else stay in MEM
REQ-028 WB state: wreg=1, m2reg=lw, regrt=(I-type ALU | lw | lui), next IF.
REQ-029 Cycle counts with mem_rdy tied to 1:
- j/jal/jr: 2 cycles
- branch: 3 cycles
- ALU op: 4 cycles
- sw: 4 cycles
- lw: 5 cycles
REQ-030 mem_rdy SHALL be ignored in ID, EXE and WB.
REQ-031 op and func SHALL be held stable by the datapath from ID through WB; the block does not latch them.

Reset
REQ-032 resetn=0 SHALL force state=IF immediately, asynchronously, and hold it there while resetn=0.
REQ-033 While resetn=0, every write enable and illegal SHALL be 0; other outputs hold their IF values.
REQ-034 Reset asserted mid-instruction (including a stalled sw) SHALL abort the instruction; wmem SHALL drop in the same cycle.
REQ-035 The first fetch SHALL begin on the first rising edge after resetn rises.

Configuration
REQ-036 Macro MC_CU_HAMM_EN: when defined, hamm (R-type, func 000001) executes as an R-type ALU op with aluc=1011.
REQ-037 When MC_CU_HAMM_EN is undefined, func 000001 SHALL decode as illegal (illegal pulse in ID, no register write).

Verification
REQ-038 add with mem_rdy=1 -> states IF,ID,EXE,WB,IF; wreg=1 only in WB; aluc=0000.
REQ-039 lw with mem_rdy low for 2 cycles in both IF and MEM -> 9 cycles total; wir=1 once; m2reg=1 and wreg=1 in WB.
REQ-040 beq with z=1 and then z=0 -> EXE gives wpc=1, pcsource=01 in the first case and wpc=0 in the second; both return to IF.
REQ-041 jal -> ID gives wpc=1, pcsource=11, wreg=1, jal=1; next state IF.
REQ-042 sw stalled in MEM, then resetn pulsed low -> state=000 and wmem=0 asynchronously; normal fetch resumes after release.
REQ-043 op=111111 -> illegal=1 for one cycle in ID, no write enables, return to IF; repeat with func=000001, which must show illegal=1 when MC_CU_HAMM_EN is undefined and wreg=1 in WB with aluc=1011 when it is defined.
